// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. One WIDTH/SEGS-bit segment
// resolves per stage; the inter-segment carry is registered, and the
// registers of the last stage are the output registers.
module cla_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GRP   = 4,
  parameter int unsigned SEGS  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEGS_NZ = (SEGS == 0) ? 1 : SEGS;
  localparam int unsigned GRP_NZ  = (GRP == 0) ? 1 : GRP;
  localparam int unsigned SEG_W   = WIDTH / SEGS_NZ;
  localparam int unsigned NGRP    = SEG_W / GRP_NZ;
  localparam int unsigned LAST    = SEGS_NZ - 1;

  // Reject geometries that do not tile the operand into whole groups.
  if ((SEGS * GRP == 0) || (WIDTH == 0) || ((WIDTH % (SEGS_NZ * GRP_NZ)) != 0)) begin : g_param_err
    $error("cla_pipe: WIDTH must be a nonzero multiple of SEGS*GRP");
  end

  // One segment: carry-lookahead inside each group, group carries chained.
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                             input logic [SEG_W-1:0] y,
                                             input logic             cin);
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] sum;
    logic             gc;
    logic             gg;
    logic             gp;
    p   = x ^ y;
    g   = x & y;
    sum = '0;
    gc  = cin;
    for (int unsigned j = 0; j < NGRP; j++) begin
      // gg/gp are the generate/propagate prefixes of the bits below bit i.
      gg = 1'b0;
      gp = 1'b1;
      for (int unsigned i = 0; i < GRP; i++) begin
        sum[j*GRP+i] = p[j*GRP+i] ^ (gg | (gp & gc));
        gg           = g[j*GRP+i] | (p[j*GRP+i] & gg);
        gp           = gp & p[j*GRP+i];
      end
      gc = gg | (gp & gc);
    end
    return {gc, sum};
  endfunction

  logic [WIDTH-1:0] a_q [SEGS_NZ];
  logic [WIDTH-1:0] b_q [SEGS_NZ];
  logic [WIDTH-1:0] s_q [SEGS_NZ];
  logic             c_q [SEGS_NZ];
  logic             v_q [SEGS_NZ];
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] pa [SEGS_NZ];
  logic [WIDTH-1:0] pb [SEGS_NZ];
  logic [WIDTH-1:0] ps [SEGS_NZ];
  logic             pc [SEGS_NZ];
  logic             pv [SEGS_NZ];

  logic [SEG_W:0]   sum_c [SEGS_NZ];
  logic [WIDTH-1:0] s_d   [SEGS_NZ];
  logic             c_d   [SEGS_NZ];
  logic             ovf_d;
  logic             zero_d;
  logic             advance;

  // Global stall: everything, bubbles included, moves only when the head can leave.
  assign advance   = !v_q[LAST] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign co        = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Stage inputs: conditioned operands for stage 0, previous stage register otherwise.
  always_comb begin
    pa[0] = a;
    pb[0] = op_sub ? ~b : b;
    pc[0] = op_sub | ci;
    ps[0] = '0;
    pv[0] = in_valid;
    for (int unsigned k = 1; k < SEGS_NZ; k++) begin
      pa[k] = a_q[k-1];
      pb[k] = b_q[k-1];
      pc[k] = c_q[k-1];
      ps[k] = s_q[k-1];
      pv[k] = v_q[k-1];
    end
  end

  // Each stage resolves its own segment; the last stage also forms the flags.
  always_comb begin
    for (int unsigned k = 0; k < SEGS_NZ; k++) begin
      sum_c[k]                   = seg_add(pa[k][k*SEG_W +: SEG_W], pb[k][k*SEG_W +: SEG_W], pc[k]);
      s_d[k]                     = ps[k];
      s_d[k][k*SEG_W +: SEG_W]   = sum_c[k][SEG_W-1:0];
      c_d[k]                     = sum_c[k][SEG_W];
    end
    ovf_d  = (pa[LAST][WIDTH-1] == pb[LAST][WIDTH-1]) & (s_d[LAST][WIDTH-1] != pa[LAST][WIDTH-1]);
    zero_d = (s_d[LAST] == '0);
  end

  // Stage registers; data only loads behind a valid op so results hold after they leave.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SEGS_NZ; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < SEGS_NZ; k++) begin
        v_q[k] <= pv[k];
        if (pv[k]) begin
          a_q[k] <= pa[k];
          b_q[k] <= pb[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (pv[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe.sv
// Scoreboard bench for cla_pipe: a 32-bit/2-segment and a 16-bit/4-segment instance.
module tb_cla_pipe;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        z;
    bit          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        q32[$];
  exp_t        q16[$];
  exp_t        e32;
  exp_t        e16;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, s;
  logic        ci = 1'b0, op_sub = 1'b0, co, ovf, zero;

  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ci16 = 1'b0, sub16 = 1'b0, co16, ovf16, z16;

  // Hand-computed stream: a, b, ci, sub -> s, co, ovf, zero.
  vec_t stream[8] = '{
    '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0},
    '{32'h00000010, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
    '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1},
    '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h4B4B4B4B, 1'b1, 1'b1, 1'b0}
  };

  cla_pipe #(.WIDTH(32), .GRP(4), .SEGS(2)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .zero(zero)
  );

  cla_pipe #(.WIDTH(16), .GRP(4), .SEGS(4)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .ci(ci16), .op_sub(sub16), .out_valid(ov16), .out_ready(ordy16),
    .s(s16), .co(co16), .ovf(ovf16), .zero(z16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the 32-bit instance: compare head of queue whenever a result is shown.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (q32.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected32: got s=%h with no op outstanding", s);
        end else begin
          e32 = q32[0];
          chk("s32", s, e32.s);
          chk("co32", 32'(co), 32'(e32.co));
          chk("ovf32", 32'(ovf), 32'(e32.ovf));
          chk("zero32", 32'(zero), 32'(e32.z));
          chk("in_ready32", 32'(in_ready), 32'(out_ready));
          if (out_ready) begin
            if (e32.lat) chk("latency32", 32'(cyc - e32.t0), 32'd2);
            void'(q32.pop_front());
          end
        end
      end else begin
        chk("in_ready32_idle", 32'(in_ready), 32'd1);
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (reset_n && ov16) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected16: got s=%h with no op outstanding", s16);
      end else begin
        e16 = q16[0];
        chk("s16", 32'(s16), e16.s);
        chk("co16", 32'(co16), 32'(e16.co));
        chk("ovf16", 32'(ovf16), 32'(e16.ovf));
        chk("zero16", 32'(z16), 32'(e16.z));
        if (ordy16) begin
          if (e16.lat) chk("latency16", 32'(cyc - e16.t0), 32'd4);
          void'(q16.pop_front());
        end
      end
    end
  end

  // Present one op (called just after a rising edge) and hold it until accepted.
  task automatic issue(input bit w16, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ici, input logic isub, input logic [31:0] es,
                       input logic eco, input logic eovf, input logic ez, input bit lat);
    exp_t e;
    bit   ok;
    int   n;
    e.s = es; e.co = eco; e.ovf = eovf; e.z = ez; e.lat = lat; e.t0 = cyc;
    if (w16) begin
      iv16 = 1'b1; a16 = ia[15:0]; b16 = ib[15:0]; ci16 = ici; sub16 = isub;
      q16.push_back(e);
    end else begin
      in_valid = 1'b1; a = ia; b = ib; ci = ici; op_sub = isub;
      q32.push_back(e);
    end
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = w16 ? ir16 : in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", n);
    end
    if (w16) iv16 = 1'b0;
    else in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_outstanding", 32'(q32.size() + q16.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset_n = 1'b1;
    // Reset state.
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_flags", {29'd0, co, ovf, zero}, 32'd0);
    chk("rst_out_valid16", 32'(ov16), 32'd0);

    // Wrap to zero, then carries across the segment boundary.
    issue(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
    drain();
    issue(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1);
    issue(0, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1);
    drain();

    // Subtraction; ci is ignored.
    issue(0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1);
    issue(0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1);
    drain();

    // Back-to-back stream with a three-cycle consumer stall.
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(0, stream[i].a, stream[i].b, stream[i].ci, stream[i].sub,
                stream[i].s, stream[i].co, stream[i].ovf, stream[i].z, 0);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while two ops are in flight; neither may emerge.
    out_ready = 1'b0;
    issue(0, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 0);
    issue(0, 32'h00000003, 32'h00000003, 1'b0, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0, 0);
    reset_n = 1'b0;
    idle(1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_s", s, 32'd0);
    chk("midrst_flags", {29'd0, co, ovf, zero}, 32'd0);
    reset_n = 1'b1;
    q32.delete();
    out_ready = 1'b1;
    idle(4);
    issue(0, 32'h00000100, 32'h00000200, 1'b0, 1'b0, 32'h00000300, 1'b0, 1'b0, 1'b0, 1);
    drain();

    // Narrow, deeper instance: latency 4.
    issue(1, 32'h00007FFF, 32'h00000000, 1'b1, 1'b0, 32'h00008000, 1'b0, 1'b1, 1'b0, 1);
    issue(1, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
    issue(1, 32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1);
    drain();

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
